// File: rtl/packet_handler_deadlock_detector.sv
// packet_handler_deadlock_detector
// Filters transient stalls from the per-region deadlock monitors. A deadlock is
// declared once a single monitor stays blocked for THRESHOLD consecutive cycles;
// the detector then raises a sticky flag and emits one report record over a
// valid/ready handshake.
// Optional macro DEADLOCK_TIMESTAMP_EN: adds a free-running cycle counter whose
// value at the declaration edge fills the timestamp field of rpt_data. Without
// it the timestamp field is 0.
module packet_handler_deadlock_detector #(
    parameter int NUM_MON   = 4,
    parameter int THRESHOLD = 1024,
    parameter int CNT_W     = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] block_in,
    input  logic               clear,
    output logic               deadlock,
    output logic [3:0]         deadlock_idx,
    output logic [CNT_W-1:0]   event_count,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [CNT_W+3:0]   rpt_data
);

    localparam int RW = $clog2(THRESHOLD + 1);

    typedef enum logic [1:0] {IDLE, WATCH, REPORT, LATCHED} state_t;

    state_t           state, state_d;
    logic [RW-1:0]    run_cnt, run_cnt_d;
    logic [3:0]       cand_idx, cand_idx_d;
    logic             deadlock_d;
    logic [3:0]       deadlock_idx_d;
    logic [CNT_W-1:0] event_count_d;
    logic             rpt_valid_d;
    logic [CNT_W+3:0] rpt_data_d;
    logic [CNT_W-1:0] timestamp;
    logic [15:0]      block_pad;

    // Zero-extended copy so a 4-bit candidate index never selects past the vector.
    assign block_pad = 16'(block_in);

    function automatic logic [3:0] lowest_set(input logic [NUM_MON-1:0] v);
        logic found;
        lowest_set = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < NUM_MON; i++) begin
            if (v[i] && !found) begin
                lowest_set = 4'(i);
                found      = 1'b1;
            end
        end
    endfunction

`ifdef DEADLOCK_TIMESTAMP_EN
    logic [CNT_W-1:0] cycle_cnt;

    // Free-running timestamp, wraps naturally at 2^CNT_W.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cycle_cnt <= '0;
        else        cycle_cnt <= cycle_cnt + CNT_W'(1);
    end

    assign timestamp = cycle_cnt;
`else
    assign timestamp = '0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state;
        run_cnt_d      = run_cnt;
        cand_idx_d     = cand_idx;
        deadlock_d     = deadlock;
        deadlock_idx_d = deadlock_idx;
        event_count_d  = event_count;
        rpt_valid_d    = rpt_valid;
        rpt_data_d     = rpt_data;
        case (state)
            IDLE: begin
                if (|block_in) begin
                    state_d    = WATCH;
                    cand_idx_d = lowest_set(block_in);
                    run_cnt_d  = RW'(1);
                end
            end
            WATCH: begin
                if (clear) begin
                    state_d   = IDLE;
                    run_cnt_d = '0;
                end else if (block_pad[cand_idx]) begin
                    if (run_cnt == RW'(THRESHOLD - 1)) begin
                        state_d        = REPORT;
                        deadlock_d     = 1'b1;
                        deadlock_idx_d = cand_idx;
                        rpt_valid_d    = 1'b1;
                        rpt_data_d     = {cand_idx, timestamp};
                        if (event_count != '1) event_count_d = event_count + CNT_W'(1);
                    end else begin
                        run_cnt_d = run_cnt + RW'(1);
                    end
                end else if (|block_in) begin
                    cand_idx_d = lowest_set(block_in);
                    run_cnt_d  = RW'(1);
                end else begin
                    state_d   = IDLE;
                    run_cnt_d = '0;
                end
            end
            REPORT: begin
                if (rpt_ready) begin
                    rpt_valid_d = 1'b0;
                    state_d     = LATCHED;
                end
            end
            LATCHED: begin
                if (clear) begin
                    deadlock_d = 1'b0;
                    run_cnt_d  = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_cnt      <= '0;
            cand_idx     <= '0;
            deadlock     <= 1'b0;
            deadlock_idx <= '0;
            event_count  <= '0;
            rpt_valid    <= 1'b0;
            rpt_data     <= '0;
        end else begin
            run_cnt      <= run_cnt_d;
            cand_idx     <= cand_idx_d;
            deadlock     <= deadlock_d;
            deadlock_idx <= deadlock_idx_d;
            event_count  <= event_count_d;
            rpt_valid    <= rpt_valid_d;
            rpt_data     <= rpt_data_d;
        end
    end

endmodule

// File: tb/tb_packet_handler_deadlock_detector.sv
// Testbench for packet_handler_deadlock_detector: directed scenarios plus random
// stimulus, checked by a scoreboard fed from a streak-counting reference model.
module tb_packet_handler_deadlock_detector;

    localparam int NUM_MON   = 4;
    localparam int THRESHOLD = 8;
    localparam int CNT_W     = 8;
    localparam int DW        = CNT_W + 4;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_MON-1:0] block_in = '0;
    logic               clear = 1'b0;
    logic               deadlock;
    logic [3:0]         deadlock_idx;
    logic [CNT_W-1:0]   event_count;
    logic               rpt_valid;
    logic               rpt_ready = 1'b0;
    logic [DW-1:0]      rpt_data;

    packet_handler_deadlock_detector #(
        .NUM_MON(NUM_MON),
        .THRESHOLD(THRESHOLD),
        .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .block_in(block_in),
        .clear(clear),
        .deadlock(deadlock),
        .deadlock_idx(deadlock_idx),
        .event_count(event_count),
        .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready),
        .rpt_data(rpt_data)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: length of the current candidate's blocked streak, plus
    // flags for "report outstanding" and "deadlock flagged".
    int            m_streak = 0;
    int            m_cand   = 0;
    bit            m_report = 0;
    bit            m_dead   = 0;
    int            m_didx   = 0;
    int            m_events = 0;
    int            m_cyc    = 0;
    logic [DW-1:0] exp_q[$];

    function automatic int lowest_of(input logic [NUM_MON-1:0] v);
        for (int i = 0; i < NUM_MON; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_streak = 0; m_cand = 0; m_report = 0; m_dead = 0;
            m_didx = 0; m_events = 0; m_cyc = 0;
            exp_q.delete();
        end else begin
            if (m_report) begin
                if (rpt_ready) m_report = 0;
            end else if (m_dead) begin
                if (clear) begin m_dead = 0; m_streak = 0; end
            end else if (m_streak > 0 && clear) begin
                m_streak = 0;
            end else if (m_streak > 0 && block_in[m_cand]) begin
                m_streak++;
                if (m_streak == THRESHOLD) begin
                    logic [3:0]       ci;
                    logic [CNT_W-1:0] ts;
                    ci = 4'(m_cand);
`ifdef DEADLOCK_TIMESTAMP_EN
                    ts = CNT_W'(m_cyc);
`else
                    ts = '0;
`endif
                    exp_q.push_back({ci, ts});
                    if (m_events < (1 << CNT_W) - 1) m_events++;
                    m_dead = 1; m_report = 1; m_didx = m_cand; m_streak = 0;
                end
            end else if (block_in != 0) begin
                m_cand = lowest_of(block_in);
                m_streak = 1;
            end else begin
                m_streak = 0;
            end
            m_cyc = (m_cyc + 1) % (1 << CNT_W);
        end
    end

    // Monitor: compares visible outputs with the model every cycle and pops the
    // scoreboard whenever a report record transfers.
    logic [DW-1:0] prev_data = '0;
    bit            prev_hold = 0;

    always @(negedge clock) begin
        if (!reset) begin
            prev_hold = 0;
        end else begin
            check("deadlock", 64'(deadlock), 64'(m_dead));
            check("event_count", 64'(event_count), 64'(m_events));
            check("rpt_valid", 64'(rpt_valid), 64'(m_report));
            if (m_dead) check("deadlock_idx", 64'(deadlock_idx), 64'(m_didx));
            if (rpt_valid && prev_hold) check("rpt_data_stable", 64'(rpt_data), 64'(prev_data));
            if (rpt_valid && rpt_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rpt_unexpected: got %0h expected no record", rpt_data);
                end else begin
                    check("rpt_data", 64'(rpt_data), 64'(exp_q.pop_front()));
                end
            end
            prev_hold = rpt_valid && !rpt_ready;
            prev_data = rpt_data;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_deadlock"}, 64'(deadlock), 64'd0);
        check({tag, "_idx"}, 64'(deadlock_idx), 64'd0);
        check({tag, "_events"}, 64'(event_count), 64'd0);
        check({tag, "_valid"}, 64'(rpt_valid), 64'd0);
        check({tag, "_data"}, 64'(rpt_data), 64'd0);
    endtask

    initial begin
        logic [DW-1:0]    exp_rec;
        logic [CNT_W-1:0] ts100;

        #1 reset = 1'b0;
        #2 check_all_zero("reset");
        #18 reset = 1'b1;
        @(posedge clock);
        #1;

        // Steady block on monitor 1, report held off, clear during REPORT ignored.
        block_in = 4'b0010;
        cyc(8);
        check("t1_deadlock", 64'(deadlock), 64'd1);
        check("t1_idx", 64'(deadlock_idx), 64'd1);
        check("t1_valid", 64'(rpt_valid), 64'd1);
        check("t1_events", 64'(event_count), 64'd1);
        block_in = '0;
        cyc(2);
        pulse_clear();
        cyc(2);
        check("t1_still_valid", 64'(rpt_valid), 64'd1);
        rpt_ready = 1'b1;
        cyc(1);
        rpt_ready = 1'b0;
        check("t1_after_xfer_valid", 64'(rpt_valid), 64'd0);
        check("t1_latched", 64'(deadlock), 64'd1);
        cyc(2);
        pulse_clear();
        check("t1_cleared", 64'(deadlock), 64'd0);

        // 7 high, 1 low, 7 high: never declares.
        block_in = 4'b0001; cyc(7);
        block_in = 4'b0000; cyc(1);
        block_in = 4'b0001; cyc(7);
        block_in = 4'b0000; cyc(2);
        check("t2_no_deadlock", 64'(deadlock), 64'd0);
        check("t2_no_valid", 64'(rpt_valid), 64'd0);

        // Two monitors high, lower one drops: tracking restarts on index 3.
        block_in = 4'b1100; cyc(3);
        block_in = 4'b1000; cyc(7);
        check("t3_not_yet", 64'(deadlock), 64'd0);
        cyc(1);
        check("t3_deadlock", 64'(deadlock), 64'd1);
        check("t3_idx", 64'(deadlock_idx), 64'd3);
        block_in = '0;
        rpt_ready = 1'b1; cyc(1); rpt_ready = 1'b0;
        pulse_clear();

        // Declaration edge aligned to timestamp 100.
        for (int i = 0; i < 300 && ((m_cyc + THRESHOLD - 1) % (1 << CNT_W)) != 100; i++) cyc(1);
        block_in = 4'b0001;
        cyc(8);
`ifdef DEADLOCK_TIMESTAMP_EN
        ts100 = CNT_W'(100);
`else
        ts100 = '0;
`endif
        exp_rec = {4'd0, ts100};
        check("t4_timestamp", 64'(rpt_data), 64'(exp_rec));
        block_in = '0;
        rpt_ready = 1'b1; cyc(1); rpt_ready = 1'b0;
        pulse_clear();

        // Random traffic: held patterns, sporadic clear, random ready.
        for (int n = 0; n < 300; n++) begin
            int unsigned hold;
            block_in = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            hold = $urandom_range(1, 12);
            for (int unsigned k = 0; k < hold; k++) begin
                clear     = ($urandom_range(0, 7) == 0);
                rpt_ready = 1'($urandom_range(0, 1));
                cyc(1);
            end
        end
        clear = 1'b0; block_in = '0;
        rpt_ready = 1'b1; cyc(2); rpt_ready = 1'b0;
        pulse_clear();

        // Drive event_count into saturation.
        for (int n = 0; n < 260; n++) begin
            block_in = 4'b0001; rpt_ready = 1'b1;
            cyc(8);
            cyc(1);
            block_in = '0; rpt_ready = 1'b0;
            pulse_clear();
        end
        check("sat_events", 64'(event_count), 64'hFF);

        // Fresh reset, declare, clear, re-declare, then reset mid-REPORT.
        #2 reset = 1'b0;
        #10 reset = 1'b1;
        @(posedge clock); #1;
        block_in = 4'b0100; rpt_ready = 1'b1;
        cyc(9);
        rpt_ready = 1'b0; block_in = '0;
        pulse_clear();
        block_in = 4'b0100;
        cyc(8);
        check("t6_events", 64'(event_count), 64'd2);
        check("t6_valid", 64'(rpt_valid), 64'd1);
        block_in = '0;
        cyc(1);
        #2 reset = 1'b0;
        #1 check_all_zero("midrpt");
        #10 reset = 1'b1;
        @(posedge clock); #1;
        cyc(3);
        check("t6_no_resend", 64'(rpt_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
